// File: rtl/kmap_lut_pkg.sv
// Shared constants and helpers for the programmable truth-table evaluator.
// Tables reset to odd parity, so an unconfigured engine computes XOR of its inputs.
package kmap_lut_pkg;

  localparam int EVAL_CNT_W = 16;
  localparam int MAX_N_IN   = 8;

  function automatic logic parity_init(input logic [MAX_N_IN-1:0] m);
    return ^m;
  endfunction

endpackage

// File: rtl/kmap_lut_bank.sv
// Truth-table storage: N_FN rows of 2^N_IN bits, one bit-write port and one
// asynchronous read port. Out-of-range function indices write nothing and read 0.
module kmap_lut_bank
  import kmap_lut_pkg::*;
#(
  parameter int N_IN = 3,
  parameter int N_FN = 2,
  parameter int FN_W = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [FN_W-1:0] wr_fn,
  input  logic [N_IN-1:0] wr_addr,
  input  logic            wr_data,
  input  logic [FN_W-1:0] rd_fn,
  input  logic [N_IN-1:0] rd_addr,
  output logic            rd_data
);

  localparam int DEPTH = 1 << N_IN;

  function automatic logic [DEPTH-1:0] parity_row();
    logic [DEPTH-1:0]    r;
    logic [MAX_N_IN-1:0] idx;
    r = '0;
    for (int m = 0; m < DEPTH; m++) begin
      idx  = MAX_N_IN'(m);
      r[m] = parity_init(idx);
    end
    return r;
  endfunction

  localparam logic [DEPTH-1:0] PARITY_ROW = parity_row();

  logic [DEPTH-1:0] row_q [N_FN];

  genvar gi;
  generate
    for (gi = 0; gi < N_FN; gi++) begin : g_row
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          row_q[gi] <= PARITY_ROW;
        end else if (wr_en && (wr_fn == FN_W'(gi))) begin
          row_q[gi][wr_addr] <= wr_data;
        end
      end
    end
  endgenerate

  // Read sees pre-edge contents, so a same-cycle write is not forwarded.
  always_comb begin
    rd_data = 1'b0;
    for (int f = 0; f < N_FN; f++) begin
      if (rd_fn == FN_W'(f)) begin
        rd_data = row_q[f][rd_addr];
      end
    end
  end

endmodule

// File: rtl/kmap_lut_engine.sv
// Programmable multi-function truth-table evaluator with a single registered
// valid/ready output stage, a config error flag and an accepted-request counter.
module kmap_lut_engine
  import kmap_lut_pkg::*;
#(
  parameter int N_IN = 3,
  parameter int N_FN = 2,
  parameter int FN_W = (N_FN > 1) ? $clog2(N_FN) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_we,
  input  logic [FN_W-1:0]       cfg_fn,
  input  logic [N_IN-1:0]       cfg_addr,
  input  logic                  cfg_data,
  output logic                  cfg_err,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [FN_W-1:0]       in_fn,
  input  logic [N_IN-1:0]       in_vec,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_f,
  output logic                  out_err,
  output logic [EVAL_CNT_W-1:0] eval_count
);

  logic                  out_valid_q, out_valid_d;
  logic                  out_f_q, out_f_d;
  logic                  out_err_q, out_err_d;
  logic                  cfg_err_q, cfg_err_d;
  logic [EVAL_CNT_W-1:0] eval_count_q, eval_count_d;
  logic                  rd_data;
  logic                  accept;
  logic                  in_oob;
  logic                  cfg_oob;

  kmap_lut_bank #(
    .N_IN (N_IN),
    .N_FN (N_FN),
    .FN_W (FN_W)
  ) u_bank (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (cfg_we),
    .wr_fn   (cfg_fn),
    .wr_addr (cfg_addr),
    .wr_data (cfg_data),
    .rd_fn   (in_fn),
    .rd_addr (in_vec),
    .rd_data (rd_data)
  );

  assign in_oob   = (32'(in_fn) >= N_FN);
  assign cfg_oob  = (32'(cfg_fn) >= N_FN);
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_f_d      = out_f_q;
    out_err_d    = out_err_q;
    eval_count_d = eval_count_q;
    cfg_err_d    = cfg_we && cfg_oob;
    if (accept) begin
      out_valid_d  = 1'b1;
      out_f_d      = in_oob ? 1'b0 : rd_data;
      out_err_d    = in_oob;
      eval_count_d = eval_count_q + 1'b1;
    end else if (out_ready) begin
      // Drained without a replacement: result bits keep their last value.
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_f_q      <= 1'b0;
      out_err_q    <= 1'b0;
      cfg_err_q    <= 1'b0;
      eval_count_q <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_f_q      <= out_f_d;
      out_err_q    <= out_err_d;
      cfg_err_q    <= cfg_err_d;
      eval_count_q <= eval_count_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_f      = out_f_q;
  assign out_err    = out_err_q;
  assign cfg_err    = cfg_err_q;
  assign eval_count = eval_count_q;

endmodule

// File: tb/tb_kmap_lut_engine.sv
// Directed bench for kmap_lut_engine with N_IN=3, N_FN=3 (FN_W=2, so fn 3 is out of range).
module tb_kmap_lut_engine;

  localparam int N_IN = 3;
  localparam int N_FN = 3;
  localparam int FN_W = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            cfg_we = 1'b0;
  logic [FN_W-1:0] cfg_fn = '0;
  logic [N_IN-1:0] cfg_addr = '0;
  logic            cfg_data = 1'b0;
  logic            cfg_err;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [FN_W-1:0] in_fn = '0;
  logic [N_IN-1:0] in_vec = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic            out_f;
  logic            out_err;
  logic [15:0]     eval_count;

  int total_cnt = 0;
  int pass_cnt  = 0;
  int exp_cnt   = 0;

  typedef struct {
    logic [FN_W-1:0] fn;
    logic [N_IN-1:0] vec;
    logic            exp_f;
    logic            exp_err;
  } vec_t;

  vec_t vecs [16];

  kmap_lut_engine #(
    .N_IN (N_IN),
    .N_FN (N_FN),
    .FN_W (FN_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_we     (cfg_we),
    .cfg_fn     (cfg_fn),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .cfg_err    (cfg_err),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_fn      (in_fn),
    .in_vec     (in_vec),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_f      (out_f),
    .out_err    (out_err),
    .eval_count (eval_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    step();
  endtask

  // One accepted evaluation: result must be visible right after the accepting edge.
  task automatic eval(input logic [FN_W-1:0] fn, input logic [N_IN-1:0] vec,
                      input logic exp_f, input logic exp_err);
    in_valid = 1'b1;
    in_fn    = fn;
    in_vec   = vec;
    step();
    exp_cnt++;
    $display("eval fn=%0d vec=%0d -> f=%0d err=%0d count=%0d (exp f=%0d err=%0d count=%0d)",
             fn, vec, out_f, out_err, eval_count, exp_f, exp_err, exp_cnt);
    check("eval_valid", 32'(out_valid), 32'd1);
    check("eval_f", 32'(out_f), 32'(exp_f));
    check("eval_err", 32'(out_err), 32'(exp_err));
    check("eval_count", 32'(eval_count), 32'(exp_cnt));
  endtask

  task automatic cfg_write(input logic [FN_W-1:0] fn, input logic [N_IN-1:0] addr,
                           input logic data);
    cfg_we   = 1'b1;
    cfg_fn   = fn;
    cfg_addr = addr;
    cfg_data = data;
    step();
    cfg_we   = 1'b0;
  endtask

  initial begin
    // Parity table 0,1,1,0,1,0,0,1 on fn 0 then fn 1.
    for (int i = 0; i < 16; i++) begin
      vecs[i].fn      = FN_W'(i / 8);
      vecs[i].vec     = N_IN'(i % 8);
      vecs[i].exp_f   = ^(N_IN'(i % 8));
      vecs[i].exp_err = 1'b0;
    end

    step();
    step();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_f", 32'(out_f), 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    check("rst_cfg_err", 32'(cfg_err), 32'd0);
    check("rst_eval_count", 32'(eval_count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    step();

    for (int i = 0; i < 16; i++) begin
      eval(vecs[i].fn, vecs[i].vec, vecs[i].exp_f, vecs[i].exp_err);
    end
    idle();
    check("sweep_count", 32'(eval_count), 32'd16);
    check("sweep_drain", 32'(out_valid), 32'd0);

    // fn 1 becomes AND.
    for (int a = 0; a < 8; a++) begin
      cfg_write(2'd1, N_IN'(a), a == 7);
      check("cfg_err_inrange", 32'(cfg_err), 32'd0);
    end
    eval(2'd1, 3'd7, 1'b1, 1'b0);
    eval(2'd1, 3'd6, 1'b0, 1'b0);
    eval(2'd0, 3'd7, 1'b1, 1'b0);
    eval(2'd1, 3'd0, 1'b0, 1'b0);

    // Same-cycle write and read of table[0][3]: old bit first, new bit next.
    cfg_we = 1'b1; cfg_fn = 2'd0; cfg_addr = 3'd3; cfg_data = 1'b1;
    eval(2'd0, 3'd3, 1'b0, 1'b0);
    cfg_we = 1'b0;
    eval(2'd0, 3'd3, 1'b1, 1'b0);
    idle();

    // Backpressure: one accept, then 4 stalled cycles with a different request pending.
    out_ready = 1'b0;
    eval(2'd0, 3'd1, 1'b1, 1'b0);
    in_vec = 3'd0;
    for (int c = 0; c < 4; c++) begin
      step();
      $display("stall cycle %0d: ready=%0d valid=%0d f=%0d count=%0d", c, in_ready, out_valid, out_f, eval_count);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_f", 32'(out_f), 32'd1);
      check("stall_count", 32'(eval_count), 32'(exp_cnt));
    end
    out_ready = 1'b1;
    #1;
    check("release_in_ready", 32'(in_ready), 32'd1);
    eval(2'd0, 3'd0, 1'b0, 1'b0);
    eval(2'd0, 3'd7, 1'b1, 1'b0);
    idle();
    check("release_drain", 32'(out_valid), 32'd0);

    // Out-of-range function index.
    eval(2'd3, 3'd1, 1'b0, 1'b1);
    eval(2'd2, 3'd1, 1'b1, 1'b0);
    idle();
    cfg_write(2'd3, 3'd1, 1'b1);
    check("cfg_err_pulse1", 32'(cfg_err), 32'd1);
    cfg_write(2'd3, 3'd2, 1'b0);
    check("cfg_err_pulse2", 32'(cfg_err), 32'd1);
    step();
    check("cfg_err_clear", 32'(cfg_err), 32'd0);
    eval(2'd1, 3'd1, 1'b0, 1'b0);
    eval(2'd2, 3'd2, 1'b1, 1'b0);
    eval(2'd0, 3'd2, 1'b1, 1'b0);
    idle();

    // Reset mid-stream while a result is held.
    cfg_write(2'd0, 3'd0, 1'b1);
    out_ready = 1'b0;
    eval(2'd0, 3'd0, 1'b1, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    exp_cnt = 0;
    $display("async reset: valid=%0d f=%0d err=%0d count=%0d", out_valid, out_f, out_err, eval_count);
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_f", 32'(out_f), 32'd0);
    check("arst_err", 32'(out_err), 32'd0);
    check("arst_count", 32'(eval_count), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    step();
    eval(2'd0, 3'd0, 1'b0, 1'b0);
    eval(2'd0, 3'd3, 1'b0, 1'b0);
    eval(2'd1, 3'd7, 1'b1, 1'b0);
    eval(2'd1, 3'd1, 1'b1, 1'b0);
    idle();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
